// File: rtl/mure_pkg.sv
// mure_pkg: shared width defaults for the trace block interface.
//   XLEN        - address / tval width
//   IRETIRE_LEN - retired-size field width, in 16-bit half-words
//   ITYPE_LEN   - closing event type width
//   CAUSE_LEN   - trap cause width
//   PRIV_LEN    - privilege level width
package mure_pkg;
   localparam int unsigned XLEN        = 64;
   localparam int unsigned IRETIRE_LEN = 32;
   localparam int unsigned ITYPE_LEN   = 3;
   localparam int unsigned CAUSE_LEN   = 5;
   localparam int unsigned PRIV_LEN    = 2;
endpackage

// File: rtl/te_block_expander.sv
// te_block_expander: re-expands one retirement block (start PC, size in
// half-words, last-instruction size, closing event) into a stream of one
// instruction per output handshake. Intermediate instruction sizes come from
// a same-cycle lookup port (fetch_pc_o -> fetch_compressed_i).
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   valid_i / ready_o        block handshake
//   iretire_i, ilastsize_i   block size (half-words), last insn is 32-bit
//   itype_i, cause_i,
//   tval_i, priv_i           closing event fields
//   iaddr_i                  PC of first instruction in the block
//   fetch_pc_o               PC currently being sized
//   fetch_compressed_i       1 = instruction at fetch_pc_o is 16-bit
//   inst_valid_o / inst_ready_i  per-instruction handshake
//   inst_pc_o, inst_compressed_o, inst_last_o, inst_noinst_o
//   inst_itype_o, inst_cause_o, inst_tval_o, inst_priv_o
//                            beat payload; event fields only on last beat
//   error_o                  one-cycle pulse: block inconsistent with lookup
module te_block_expander #(
   parameter int unsigned XLEN        = mure_pkg::XLEN,
   parameter int unsigned IRETIRE_LEN = mure_pkg::IRETIRE_LEN,
   parameter int unsigned ITYPE_LEN   = mure_pkg::ITYPE_LEN,
   parameter int unsigned CAUSE_LEN   = mure_pkg::CAUSE_LEN,
   parameter int unsigned PRIV_LEN    = mure_pkg::PRIV_LEN
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [IRETIRE_LEN-1:0] iretire_i,
   input  logic                   ilastsize_i,
   input  logic [ITYPE_LEN-1:0]   itype_i,
   input  logic [CAUSE_LEN-1:0]   cause_i,
   input  logic [XLEN-1:0]        tval_i,
   input  logic [PRIV_LEN-1:0]    priv_i,
   input  logic [XLEN-1:0]        iaddr_i,
   output logic [XLEN-1:0]        fetch_pc_o,
   input  logic                   fetch_compressed_i,
   output logic                   inst_valid_o,
   input  logic                   inst_ready_i,
   output logic [XLEN-1:0]        inst_pc_o,
   output logic                   inst_compressed_o,
   output logic                   inst_last_o,
   output logic                   inst_noinst_o,
   output logic [ITYPE_LEN-1:0]   inst_itype_o,
   output logic [CAUSE_LEN-1:0]   inst_cause_o,
   output logic [XLEN-1:0]        inst_tval_o,
   output logic [PRIV_LEN-1:0]    inst_priv_o,
   output logic                   error_o
);

   typedef enum logic [1:0] {IDLE, EXPAND, EVENT} state_t;

   state_t                 state_q;
   logic [XLEN-1:0]        pc_q;
   logic [IRETIRE_LEN-1:0] rem_q;
   logic                   ilastsize_q;
   logic [ITYPE_LEN-1:0]   itype_q;
   logic [CAUSE_LEN-1:0]   cause_q;
   logic [XLEN-1:0]        tval_q;
   logic [PRIV_LEN-1:0]    priv_q;
   logic                   error_q;

   logic [IRETIRE_LEN-1:0] sz;
   logic [IRETIRE_LEN-1:0] last_sz;
   logic                   is_last;
   logic                   err;

   // Size of the instruction at pc_q and the consistency checks against the
   // remaining block size; only meaningful while expanding.
   always_comb begin
      sz      = fetch_compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
      last_sz = ilastsize_q ? IRETIRE_LEN'(2) : IRETIRE_LEN'(1);
      is_last = (rem_q == sz);
      err     = (state_q == EXPAND) && ((rem_q < sz) || (is_last && (sz != last_sz)));
   end

   assign ready_o    = (state_q == IDLE);
   assign fetch_pc_o = pc_q;
   assign error_o    = error_q;

   always_comb begin
      inst_valid_o      = 1'b0;
      inst_pc_o         = '0;
      inst_compressed_o = 1'b0;
      inst_last_o       = 1'b0;
      inst_noinst_o     = 1'b0;
      inst_itype_o      = '0;
      inst_cause_o      = '0;
      inst_tval_o       = '0;
      inst_priv_o       = '0;
      unique case (state_q)
         EXPAND: begin
            if (!err) begin
               inst_valid_o      = 1'b1;
               inst_pc_o         = pc_q;
               inst_compressed_o = fetch_compressed_i;
               inst_last_o       = is_last;
               if (is_last) begin
                  inst_itype_o = itype_q;
                  inst_cause_o = cause_q;
                  inst_tval_o  = tval_q;
                  inst_priv_o  = priv_q;
               end
            end
         end
         EVENT: begin
            inst_valid_o  = 1'b1;
            inst_last_o   = 1'b1;
            inst_noinst_o = 1'b1;
            inst_itype_o  = itype_q;
            inst_cause_o  = cause_q;
            inst_tval_o   = tval_q;
            inst_priv_o   = priv_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         rem_q       <= '0;
         ilastsize_q <= 1'b0;
         itype_q     <= '0;
         cause_q     <= '0;
         tval_q      <= '0;
         priv_q      <= '0;
         error_q     <= 1'b0;
      end else begin
         error_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (valid_i) begin
                  pc_q        <= iaddr_i;
                  rem_q       <= iretire_i;
                  ilastsize_q <= ilastsize_i;
                  itype_q     <= itype_i;
                  cause_q     <= cause_i;
                  tval_q      <= tval_i;
                  priv_q      <= priv_i;
                  state_q     <= (iretire_i == '0) ? EVENT : EXPAND;
               end
            end
            EXPAND: begin
               if (err) begin
                  // Inconsistent block is dropped; the pulse lands in the
                  // IDLE cycle that follows.
                  error_q <= 1'b1;
                  state_q <= IDLE;
               end else if (inst_ready_i) begin
                  if (is_last) begin
                     state_q <= IDLE;
                  end else begin
                     pc_q  <= pc_q + (fetch_compressed_i ? XLEN'(2) : XLEN'(4));
                     rem_q <= rem_q - sz;
                  end
               end
            end
            EVENT: begin
               if (inst_ready_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_te_block_expander.sv
// tb_te_block_expander: scoreboard bench for te_block_expander. Expected
// beats are queued when a block is driven and compared as the DUT hands
// each beat out; the instruction-size lookup is a small program table.
module tb_te_block_expander;
   localparam int unsigned XLEN        = mure_pkg::XLEN;
   localparam int unsigned IRETIRE_LEN = mure_pkg::IRETIRE_LEN;
   localparam int unsigned ITYPE_LEN   = mure_pkg::ITYPE_LEN;
   localparam int unsigned CAUSE_LEN   = mure_pkg::CAUSE_LEN;
   localparam int unsigned PRIV_LEN    = mure_pkg::PRIV_LEN;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   valid = 1'b0;
   logic                   ready;
   logic [IRETIRE_LEN-1:0] iretire = '0;
   logic                   ilastsize = 1'b0;
   logic [ITYPE_LEN-1:0]   itype = '0;
   logic [CAUSE_LEN-1:0]   cause = '0;
   logic [XLEN-1:0]        tval = '0;
   logic [PRIV_LEN-1:0]    priv = '0;
   logic [XLEN-1:0]        iaddr = '0;
   logic [XLEN-1:0]        fetch_pc;
   logic                   fetch_compressed;
   logic                   inst_valid;
   logic                   inst_ready = 1'b1;
   logic [XLEN-1:0]        inst_pc;
   logic                   inst_compressed;
   logic                   inst_last;
   logic                   inst_noinst;
   logic [ITYPE_LEN-1:0]   inst_itype;
   logic [CAUSE_LEN-1:0]   inst_cause;
   logic [XLEN-1:0]        inst_tval;
   logic [PRIV_LEN-1:0]    inst_priv;
   logic                   error;

   te_block_expander #(
      .XLEN(XLEN), .IRETIRE_LEN(IRETIRE_LEN), .ITYPE_LEN(ITYPE_LEN),
      .CAUSE_LEN(CAUSE_LEN), .PRIV_LEN(PRIV_LEN)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
      .iretire_i(iretire), .ilastsize_i(ilastsize), .itype_i(itype),
      .cause_i(cause), .tval_i(tval), .priv_i(priv), .iaddr_i(iaddr),
      .fetch_pc_o(fetch_pc), .fetch_compressed_i(fetch_compressed),
      .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
      .inst_pc_o(inst_pc), .inst_compressed_o(inst_compressed),
      .inst_last_o(inst_last), .inst_noinst_o(inst_noinst),
      .inst_itype_o(inst_itype), .inst_cause_o(inst_cause),
      .inst_tval_o(inst_tval), .inst_priv_o(inst_priv), .error_o(error)
   );

   always #5 clk = ~clk;

   // Program image: 1 = 16-bit instruction at that half-word slot.
   logic comp_tab [16];
   assign fetch_compressed = comp_tab[fetch_pc[4:1]];

   typedef struct packed {
      logic [XLEN-1:0]      pc;
      logic                 comp;
      logic                 last;
      logic                 noinst;
      logic [ITYPE_LEN-1:0] itype;
      logic [CAUSE_LEN-1:0] cause;
      logic [XLEN-1:0]      tval;
      logic [PRIV_LEN-1:0]  priv;
   } beat_t;

   beat_t sb[$];
   logic  rdy_pat[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_err    = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_beat(input logic [XLEN-1:0] pc, input logic comp, input logic last,
                            input logic noinst, input logic [ITYPE_LEN-1:0] ty,
                            input logic [CAUSE_LEN-1:0] ca, input logic [XLEN-1:0] tv,
                            input logic [PRIV_LEN-1:0] pr);
      beat_t b;
      b.pc = pc; b.comp = comp; b.last = last; b.noinst = noinst;
      b.itype = ty; b.cause = ca; b.tval = tv; b.priv = pr;
      sb.push_back(b);
   endtask

   task automatic clear_tab();
      for (int i = 0; i < 16; i++) comp_tab[i] = 1'b0;
   endtask

   // Output driver for inst_ready: one pattern entry per cycle, else 1.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_pat.size() > 0) inst_ready = rdy_pat.pop_front();
         else inst_ready = 1'b1;
      end
   end

   // Monitor: stall stability, idle-zero fields, scoreboard pops, error pulses.
   logic  hold_v = 1'b0;
   beat_t hold_b;
   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (error) n_err++;
         if (hold_v) begin
            check("stall_pc", inst_pc, hold_b.pc);
            check("stall_ctl", {63'd0, inst_valid} << 3 | {61'd0, inst_compressed, inst_last, inst_noinst},
                  {60'd0, 1'b1, hold_b.comp, hold_b.last, hold_b.noinst});
         end
         if (!inst_valid) begin
            check("idle_zero", {56'd0, |inst_pc, inst_compressed, inst_last, inst_noinst,
                                |inst_itype, |inst_cause, |inst_tval, |inst_priv}, 64'd0);
         end
         if (inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", inst_pc, 64'hFFFF_FFFF_FFFF_FFFF ^ inst_pc);
            end else begin
               e = sb.pop_front();
               check("beat_pc", inst_pc, e.pc);
               check("beat_flags", {61'd0, inst_compressed, inst_last, inst_noinst},
                     {61'd0, e.comp, e.last, e.noinst});
               check("beat_event", {54'd0, inst_itype, inst_cause, inst_priv},
                     {54'd0, e.itype, e.cause, e.priv});
               check("beat_tval", inst_tval, e.tval);
            end
         end
         hold_v = inst_valid && !inst_ready;
         hold_b.pc = inst_pc; hold_b.comp = inst_compressed;
         hold_b.last = inst_last; hold_b.noinst = inst_noinst;
      end
   end

   task automatic send(input logic [XLEN-1:0] a, input logic [IRETIRE_LEN-1:0] n,
                       input logic ls, input logic [ITYPE_LEN-1:0] ty,
                       input logic [CAUSE_LEN-1:0] ca, input logic [XLEN-1:0] tv,
                       input logic [PRIV_LEN-1:0] pr);
      int w = 0;
      while (!ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      check("accept_ready", {63'd0, ready}, 64'd1);
      iaddr = a; iretire = n; ilastsize = ls; itype = ty; cause = ca; tval = tv; priv = pr;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      check("first_valid", {63'd0, inst_valid}, 64'd1);
   endtask

   task automatic drain();
      int w = 0;
      while ((sb.size() != 0 || !ready) && w < 100) begin
         @(posedge clk); #1; w++;
      end
      check("drain", {62'd0, sb.size() == 0, ready}, 64'd3);
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   int e0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      clear_tab();
      #1;
      check("rst_ready", {63'd0, ready}, 64'd1);
      check("rst_valid", {63'd0, inst_valid}, 64'd0);
      check("rst_error", {63'd0, error}, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Mixed C / 32-bit block.
      e0 = n_err; clear_tab(); comp_tab[0] = 1'b1;
      push_beat(64'h1000, 1, 0, 0, 0, 0, 0, 0);
      push_beat(64'h1002, 0, 0, 0, 0, 0, 0, 0);
      push_beat(64'h1006, 0, 1, 0, 0, 0, 0, 0);
      send(64'h1000, 5, 1, 0, 0, 0, 0);
      drain();
      check("t1_no_err", 64'(n_err - e0), 64'd0);

      // Event-only block.
      e0 = n_err;
      push_beat(64'h0, 0, 1, 1, 1, 2, 64'hdead, 0);
      send(64'h2000, 0, 0, 1, 2, 64'hdead, 0);
      drain();
      check("t2_no_err", 64'(n_err - e0), 64'd0);

      // Remaining 1 half-word but 32-bit instruction.
      e0 = n_err; clear_tab();
      push_beat(64'h3000, 0, 0, 0, 0, 0, 0, 0);
      send(64'h3000, 3, 1, 0, 0, 0, 0);
      drain();
      check("t3_err_pulse", 64'(n_err - e0), 64'd1);

      // Last instruction size disagrees with ilastsize.
      e0 = n_err; clear_tab();
      push_beat(64'h4000, 0, 0, 0, 0, 0, 0, 0);
      send(64'h4000, 4, 0, 0, 0, 0, 0);
      drain();
      check("t4_err_pulse", 64'(n_err - e0), 64'd1);

      // Backpressure with event on last beat.
      e0 = n_err; clear_tab(); comp_tab[0] = 1'b1;
      push_beat(64'h1000, 1, 0, 0, 0, 0, 0, 0);
      push_beat(64'h1002, 0, 0, 0, 0, 0, 0, 0);
      push_beat(64'h1006, 0, 1, 0, 3, 0, 0, 3);
      rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b0);
      rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b1);
      send(64'h1000, 5, 1, 3, 0, 0, 3);
      drain();
      check("t5_no_err", 64'(n_err - e0), 64'd0);

      // All-compressed block ending on a 16-bit instruction.
      e0 = n_err; clear_tab(); comp_tab[0] = 1'b1; comp_tab[1] = 1'b1;
      push_beat(64'h3000, 1, 0, 0, 0, 0, 0, 0);
      push_beat(64'h3002, 1, 1, 0, 0, 0, 0, 0);
      send(64'h3000, 2, 0, 0, 0, 0, 0);
      drain();
      check("t6_no_err", 64'(n_err - e0), 64'd0);

      // PC wrap at the top of the address space.
      e0 = n_err; clear_tab();
      push_beat(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
      push_beat(64'h0, 0, 1, 0, 0, 0, 0, 0);
      send(64'hFFFF_FFFF_FFFF_FFFC, 4, 1, 0, 0, 0, 0);
      drain();
      check("t7_no_err", 64'(n_err - e0), 64'd0);

      // Reset mid-block while stalled, then a clean block.
      e0 = n_err; clear_tab();
      for (int i = 0; i < 20; i++) rdy_pat.push_back(1'b0);
      send(64'h5000, 4, 1, 0, 0, 0, 0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {63'd0, inst_valid}, 64'd0);
      check("midrst_ready", {63'd0, ready}, 64'd1);
      check("midrst_error", {63'd0, error}, 64'd0);
      rdy_pat.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_tab(); comp_tab[0] = 1'b1;
      push_beat(64'h1000, 1, 0, 0, 0, 0, 0, 0);
      push_beat(64'h1002, 0, 0, 0, 0, 0, 0, 0);
      push_beat(64'h1006, 0, 1, 0, 0, 0, 0, 0);
      send(64'h1000, 5, 1, 0, 0, 0, 0);
      drain();
      check("t8_no_err", 64'(n_err - e0), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
